// File: rtl/cache_ctrl_if.sv
// Core-side load/store channel of cache_ctrl: request handshake plus one-cycle response pulse.
// The core drives through the master modport, the controller through the slave modport.
interface cache_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: single-outstanding load/store controller for a direct-mapped write-back cache.
// Defining CACHE_CTRL_PERF_CNT_EN adds saturating hit/miss counters o_hit_count / o_miss_count.
module cache_ctrl #(
    parameter int OPTN_DATA_WIDTH      = 32,
    parameter int OPTN_ADDR_WIDTH      = 32,
    parameter int OPTN_CACHE_SIZE      = 1024,
    parameter int OPTN_CACHE_LINE_SIZE = 32,
    localparam int CACHE_INDEX_COUNT   = OPTN_CACHE_SIZE / OPTN_CACHE_LINE_SIZE,
    localparam int CACHE_INDEX_WIDTH   = $clog2(CACHE_INDEX_COUNT),
    localparam int CACHE_LINE_WIDTH    = OPTN_CACHE_LINE_SIZE * 8,
    localparam int WORD_OFFSET_WIDTH   = $clog2(CACHE_LINE_WIDTH / OPTN_DATA_WIDTH),
    localparam int BYTE_OFFSET_WIDTH   = $clog2(OPTN_DATA_WIDTH / 8),
    localparam int CACHE_TAG_WIDTH     = OPTN_ADDR_WIDTH - CACHE_INDEX_WIDTH
                                         - WORD_OFFSET_WIDTH - BYTE_OFFSET_WIDTH
) (
    input  logic                         clk,
    input  logic                         n_rst,
    cache_ctrl_if.slave                  core,
    output logic                         o_cache_rd_en,
    output logic [CACHE_INDEX_WIDTH-1:0] o_cache_rd_index,
    input  logic                         i_cache_rd_valid,
    input  logic                         i_cache_rd_dirty,
    input  logic [CACHE_TAG_WIDTH-1:0]   i_cache_rd_tag,
    input  logic [CACHE_LINE_WIDTH-1:0]  i_cache_rd_data,
    output logic                         o_cache_wr_en,
    output logic [CACHE_INDEX_WIDTH-1:0] o_cache_wr_index,
    output logic                         o_cache_wr_valid,
    output logic                         o_cache_wr_dirty,
    output logic [CACHE_TAG_WIDTH-1:0]   o_cache_wr_tag,
    output logic [CACHE_LINE_WIDTH-1:0]  o_cache_wr_data,
    output logic                         o_mem_req_valid,
    input  logic                         i_mem_req_ready,
    output logic                         o_mem_req_we,
    output logic [OPTN_ADDR_WIDTH-1:0]   o_mem_req_addr,
    output logic [CACHE_LINE_WIDTH-1:0]  o_mem_req_data,
    input  logic                         i_mem_rsp_valid,
    input  logic [CACHE_LINE_WIDTH-1:0]  i_mem_rsp_data
`ifdef CACHE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                  o_hit_count,
    output logic [31:0]                  o_miss_count
`endif
);

    localparam int LINE_OFFSET_WIDTH = WORD_OFFSET_WIDTH + BYTE_OFFSET_WIDTH;

    typedef enum logic [2:0] {
        IDLE, COMPARE, WRITEBACK, FILL_REQ, FILL_WAIT, INSTALL, RESPOND
    } state_t;

    state_t                         state;
    logic                           req_we;
    logic [CACHE_TAG_WIDTH-1:0]     req_tag;
    logic [CACHE_INDEX_WIDTH-1:0]   req_index;
    logic [WORD_OFFSET_WIDTH-1:0]   req_word;
    logic [OPTN_DATA_WIDTH-1:0]     req_data;
    logic [CACHE_LINE_WIDTH-1:0]    fill_line;

    logic [CACHE_TAG_WIDTH-1:0]     addr_tag;
    logic [CACHE_INDEX_WIDTH-1:0]   addr_index;
    logic [WORD_OFFSET_WIDTH-1:0]   addr_word;
    logic                           unused_byte_offset;
    logic                           cache_hit;

    assign addr_tag           = core.req_addr[OPTN_ADDR_WIDTH-1 -: CACHE_TAG_WIDTH];
    assign addr_index         = core.req_addr[OPTN_ADDR_WIDTH-CACHE_TAG_WIDTH-1 -: CACHE_INDEX_WIDTH];
    assign addr_word          = core.req_addr[LINE_OFFSET_WIDTH-1 -: WORD_OFFSET_WIDTH];
    assign unused_byte_offset = ^core.req_addr[BYTE_OFFSET_WIDTH-1:0];
    assign cache_hit          = i_cache_rd_valid && (i_cache_rd_tag == req_tag);

    function automatic logic [OPTN_DATA_WIDTH-1:0] word_of(
        input logic [CACHE_LINE_WIDTH-1:0]  line,
        input logic [WORD_OFFSET_WIDTH-1:0] word
    );
        return line[int'(word)*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH];
    endfunction

    function automatic logic [CACHE_LINE_WIDTH-1:0] merge_word(
        input logic [CACHE_LINE_WIDTH-1:0]  line,
        input logic [WORD_OFFSET_WIDTH-1:0] word,
        input logic [OPTN_DATA_WIDTH-1:0]   data
    );
        logic [CACHE_LINE_WIDTH-1:0] merged;
        merged = line;
        merged[int'(word)*OPTN_DATA_WIDTH +: OPTN_DATA_WIDTH] = data;
        return merged;
    endfunction

    // The array read must launch in the accept cycle and a store hit must write in the
    // compare cycle, so both array ports are decoded from state rather than registered.
    assign o_cache_rd_en    = (state == IDLE) && core.req_valid;
    assign o_cache_rd_index = o_cache_rd_en ? addr_index : '0;

    always_comb begin
        o_cache_wr_en    = 1'b0;
        o_cache_wr_index = '0;
        o_cache_wr_valid = 1'b0;
        o_cache_wr_dirty = 1'b0;
        o_cache_wr_tag   = '0;
        o_cache_wr_data  = '0;
        if (state == COMPARE && req_we && cache_hit) begin
            o_cache_wr_en    = 1'b1;
            o_cache_wr_index = req_index;
            o_cache_wr_valid = 1'b1;
            o_cache_wr_dirty = 1'b1;
            o_cache_wr_tag   = req_tag;
            o_cache_wr_data  = merge_word(i_cache_rd_data, req_word, req_data);
        end else if (state == INSTALL) begin
            o_cache_wr_en    = 1'b1;
            o_cache_wr_index = req_index;
            o_cache_wr_valid = 1'b1;
            o_cache_wr_dirty = req_we;
            o_cache_wr_tag   = req_tag;
            o_cache_wr_data  = req_we ? merge_word(fill_line, req_word, req_data) : fill_line;
        end
    end

    // Main sequencer; the memory request registers double as the captured victim line.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            core.req_ready  <= 1'b1;
            core.rsp_valid  <= 1'b0;
            core.rsp_data   <= '0;
            o_mem_req_valid <= 1'b0;
            o_mem_req_we    <= 1'b0;
            o_mem_req_addr  <= '0;
            o_mem_req_data  <= '0;
            req_we          <= 1'b0;
            req_tag         <= '0;
            req_index       <= '0;
            req_word        <= '0;
            req_data        <= '0;
            fill_line       <= '0;
        end else begin
            core.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        req_we         <= core.req_we;
                        req_tag        <= addr_tag;
                        req_index      <= addr_index;
                        req_word       <= addr_word;
                        req_data       <= core.req_data;
                        core.req_ready <= 1'b0;
                        state          <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (cache_hit) begin
                        core.rsp_valid <= 1'b1;
                        core.rsp_data  <= req_we ? '0 : word_of(i_cache_rd_data, req_word);
                        state          <= RESPOND;
                    end else if (i_cache_rd_valid && i_cache_rd_dirty) begin
                        o_mem_req_valid <= 1'b1;
                        o_mem_req_we    <= 1'b1;
                        o_mem_req_addr  <= {i_cache_rd_tag, req_index, {LINE_OFFSET_WIDTH{1'b0}}};
                        o_mem_req_data  <= i_cache_rd_data;
                        state           <= WRITEBACK;
                    end else begin
                        o_mem_req_valid <= 1'b1;
                        o_mem_req_we    <= 1'b0;
                        o_mem_req_addr  <= {req_tag, req_index, {LINE_OFFSET_WIDTH{1'b0}}};
                        o_mem_req_data  <= '0;
                        state           <= FILL_REQ;
                    end
                end
                WRITEBACK: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_we   <= 1'b0;
                        o_mem_req_addr <= {req_tag, req_index, {LINE_OFFSET_WIDTH{1'b0}}};
                        o_mem_req_data <= '0;
                        state          <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        o_mem_req_addr  <= '0;
                        state           <= FILL_WAIT;
                    end
                end
                FILL_WAIT: begin
                    if (i_mem_rsp_valid) begin
                        fill_line <= i_mem_rsp_data;
                        state     <= INSTALL;
                    end
                end
                INSTALL: begin
                    core.rsp_valid <= 1'b1;
                    core.rsp_data  <= req_we ? '0 : word_of(fill_line, req_word);
                    state          <= RESPOND;
                end
                RESPOND: begin
                    core.req_ready <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_CTRL_PERF_CNT_EN
    // Lookup outcome counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else if (state == COMPARE) begin
            if (cache_hit) begin
                if (o_hit_count != 32'hFFFF_FFFF) o_hit_count <= o_hit_count + 32'd1;
            end else begin
                if (o_miss_count != 32'hFFFF_FFFF) o_miss_count <= o_miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
